// File: rtl/multicyc_exec_if.sv
// ---------------------------------------------------------------------------
// multicyc_pkg / multicyc_exec_if
//
// Purpose:
//   Shared request/response types for the multi-cycle HI/LO unit, and the
//   interface that carries them between the execute stage and the unit.
//
// Interface signals:
//   req  : multicyc_req_t  - op, is_multicyc, hilo (current HI/LO),
//                            reg0 (rs), reg1 (rt)
//   resp : multicyc_resp_t - ready, valid, hilo result (HI = [63:32])
//
// Modports:
//   master : execute stage side (drives req, observes resp)
//   slave  : multicyc_exec side (observes req, drives resp)
// ---------------------------------------------------------------------------
package multicyc_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MADD  = 4'd3,
        OP_MADDU = 4'd4,
        OP_MSUB  = 4'd5,
        OP_MSUBU = 4'd6,
        OP_MUL   = 4'd7,
        OP_DIV   = 4'd8,
        OP_DIVU  = 4'd9,
        OP_MTHI  = 4'd10,
        OP_MTLO  = 4'd11
    } op_t;

    typedef struct packed {
        op_t         op;
        logic        is_multicyc;
        logic [63:0] hilo;
        logic [31:0] reg0;
        logic [31:0] reg1;
    } multicyc_req_t;

    typedef struct packed {
        logic        ready;
        logic        valid;
        logic [63:0] hilo;
    } multicyc_resp_t;

endpackage

interface multicyc_exec_if;
    import multicyc_pkg::*;

    multicyc_req_t  req;
    multicyc_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);

endinterface

// File: rtl/multicyc_exec.sv
// ---------------------------------------------------------------------------
// multicyc_exec
//
// Purpose:
//   Multi-cycle HI/LO arithmetic unit for the execute stage. Multiply-class
//   ops complete after MUL_LAT cycles; DIV/DIVU use a radix-2 restoring
//   divider and complete 34 cycles after acceptance. Any other op flagged
//   is_multicyc simply echoes req.hilo one cycle later.
//
// Ports:
//   clk   : clock
//   rst_n : synchronous reset, active-low
//   flush : abort the in-flight op; no response is produced for it
//   bus   : multicyc_exec_if.slave (req in, resp out)
//
// Parameters:
//   MUL_LAT : acceptance-to-valid latency of multiply-class ops (1..4)
// ---------------------------------------------------------------------------
module multicyc_exec
    import multicyc_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    multicyc_exec_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    op_t         r_op;
    logic [63:0] r_hiloIn;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [5:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic        r_negQ;
    logic        r_negR;
    logic        r_div0;
    logic        r_valid;
    logic [63:0] r_hilo;
    logic [63:0] r_hiloPrev;

    logic        w_accept;
    logic        w_divSigned;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [63:0] w_mulRes;
    logic [32:0] w_shift;
    logic [32:0] w_sub;
    logic [31:0] w_qFix;
    logic [31:0] w_rFix;
    logic [63:0] w_divRes;

    function automatic logic isMulOp(input op_t op);
        isMulOp = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                  (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU) ||
                  (op == OP_MUL);
    endfunction

    function automatic logic isDivOp(input op_t op);
        isDivOp = (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Operands are extended to 64 bits first so the low 64 bits of the
    // 64x64 product are the exact signed/unsigned 32x32 product.
    function automatic logic [63:0] mulResult(input op_t         op,
                                              input logic [63:0] acc,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic        isSigned;
        logic [63:0] extA;
        logic [63:0] extB;
        logic [63:0] prod;
        isSigned = (op == OP_MULT) || (op == OP_MADD) ||
                   (op == OP_MSUB) || (op == OP_MUL);
        extA = isSigned ? {{32{a[31]}}, a} : {32'd0, a};
        extB = isSigned ? {{32{b[31]}}, b} : {32'd0, b};
        prod = extA * extB;
        case (op)
            OP_MADD, OP_MADDU: mulResult = acc + prod;
            OP_MSUB, OP_MSUBU: mulResult = acc - prod;
            default:           mulResult = prod;
        endcase
    endfunction

    assign w_accept = (r_state == IDLE) && bus.req.is_multicyc && !flush;

    // Divider setup happens in the acceptance cycle: magnitudes are latched
    // directly so the iterations can start on the following cycle.
    assign w_divSigned = (bus.req.op == OP_DIV);
    assign w_absA = (w_divSigned && bus.req.reg0[31]) ? -bus.req.reg0 : bus.req.reg0;
    assign w_absB = (w_divSigned && bus.req.reg1[31]) ? -bus.req.reg1 : bus.req.reg1;

    // With MUL_LAT = 1 the product is taken straight from the request in
    // IDLE; otherwise it comes from the latched operands.
    always_comb begin
        if (r_state == IDLE) begin
            w_mulRes = mulResult(bus.req.op, bus.req.hilo, bus.req.reg0, bus.req.reg1);
        end else begin
            w_mulRes = mulResult(r_op, r_hiloIn, r_a, r_b);
        end
    end

    // One restoring step: the dividend shifts out of r_quo into the partial
    // remainder while quotient bits shift in from the bottom. The 33-bit
    // difference is never outside [-2^32, 2^32), so bit 32 is its sign.
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_sub    = w_shift - {1'b0, r_dvs};

    assign w_qFix   = r_negQ ? -r_quo : r_quo;
    assign w_rFix   = r_negR ? -r_rem : r_rem;
    assign w_divRes = r_div0 ? {r_a, 32'hFFFF_FFFF} : {w_rFix, w_qFix};

    // Control, datapath and registered response. r_hiloPrev keeps the last
    // delivered result so a flush landing on the DONE cycle hides the new
    // one completely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= OP_NOP;
            r_hiloIn   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
            r_div0     <= 1'b0;
            r_valid    <= 1'b0;
            r_hilo     <= '0;
            r_hiloPrev <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= bus.req.op;
                        r_hiloIn <= bus.req.hilo;
                        r_a      <= bus.req.reg0;
                        r_b      <= bus.req.reg1;
                        r_cnt    <= '0;
                        if (isMulOp(bus.req.op)) begin
                            if (MUL_LAT == 1) begin
                                r_state    <= DONE;
                                r_valid    <= 1'b1;
                                r_hiloPrev <= r_hilo;
                                r_hilo     <= w_mulRes;
                            end else begin
                                r_state <= MUL;
                            end
                        end else if (isDivOp(bus.req.op)) begin
                            r_state <= DIV;
                            r_quo   <= w_absA;
                            r_dvs   <= w_absB;
                            r_rem   <= '0;
                            r_negQ  <= w_divSigned && (bus.req.reg0[31] ^ bus.req.reg1[31]);
                            r_negR  <= w_divSigned && bus.req.reg0[31];
                            r_div0  <= (bus.req.reg1 == 32'd0);
                        end else begin
                            r_state    <= DONE;
                            r_valid    <= 1'b1;
                            r_hiloPrev <= r_hilo;
                            r_hilo     <= bus.req.hilo;
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 6'(MUL_LAT - 2)) begin
                        r_state    <= DONE;
                        r_valid    <= 1'b1;
                        r_hiloPrev <= r_hilo;
                        r_hilo     <= w_mulRes;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                DIV: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (r_cnt == 6'd32) begin
                        r_state    <= DONE;
                        r_valid    <= 1'b1;
                        r_hiloPrev <= r_hilo;
                        r_hilo     <= w_divRes;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        if (!w_sub[32]) begin
                            r_rem <= w_sub[31:0];
                            r_quo <= {r_quo[30:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[31:0];
                            r_quo <= {r_quo[30:0], 1'b0};
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    if (flush) begin
                        r_hilo <= r_hiloPrev;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // A flush in the DONE cycle suppresses the pulse in that same cycle.
    assign bus.resp.valid = r_valid && !flush;
    assign bus.resp.ready = r_valid && !flush;
    assign bus.resp.hilo  = (r_valid && flush) ? r_hiloPrev : r_hilo;

endmodule

// File: tb/tb_multicyc_exec.sv
// ---------------------------------------------------------------------------
// tb_multicyc_exec
//
// Purpose:
//   Self-checking bench for multicyc_exec. A cycle-level behavioural model
//   (result from plain arithmetic, completion cycle from op latency) is
//   compared against the DUT every cycle; directed cases pin the model with
//   hand-computed literals, then a randomized phase exercises op mixes,
//   corner operands, gaps, back-to-back issue and random flushes.
// ---------------------------------------------------------------------------
module tb_multicyc_exec;
    import multicyc_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 34;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   cycle = 0;
    int   nChecks = 0;
    int   nPass = 0;

    multicyc_exec_if busIf ();

    multicyc_exec #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (busIf.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Model state: whether an accepted op is outstanding, the cycle its
    // response is due, its result, and the hilo currently on the outputs.
    bit          mKnown = 1'b0;
    bit          mBusy = 1'b0;
    int          mDoneCycle = 0;
    logic [63:0] mResult = '0;
    logic [63:0] mShown = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    function automatic logic [63:0] refResult(input op_t op, input logic [63:0] hilo,
                                              input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] sp;
        logic [63:0] up;
        longint      q;
        longint      r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        case (op)
            OP_MULT, OP_MUL: refResult = sp;
            OP_MULTU:        refResult = up;
            OP_MADD:         refResult = hilo + sp;
            OP_MADDU:        refResult = hilo + up;
            OP_MSUB:         refResult = hilo - sp;
            OP_MSUBU:        refResult = hilo - up;
            OP_DIV: begin
                if (b == 32'd0) begin
                    refResult = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    refResult = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) refResult = {a, 32'hFFFF_FFFF};
                else            refResult = {a % b, a / b};
            end
            default:         refResult = hilo;
        endcase
    endfunction

    function automatic int refLatency(input op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
            OP_MSUB, OP_MSUBU, OP_MUL: refLatency = MUL_LAT;
            OP_DIV, OP_DIVU:           refLatency = DIV_LAT;
            default:                   refLatency = 1;
        endcase
    endfunction

    // Per-cycle compare against the model, then advance the model with the
    // inputs that will be sampled at the coming clock edge.
    always @(negedge clk) begin
        logic        expValid;
        logic [63:0] expHilo;
        if (mKnown) begin
            expValid = mBusy && (cycle == mDoneCycle) && !flush;
            expHilo  = expValid ? mResult : mShown;
            checkOutput("valid", 64'(busIf.resp.valid), 64'(expValid));
            checkOutput("ready", 64'(busIf.resp.ready), 64'(expValid));
            checkOutput("hilo", busIf.resp.hilo, expHilo);
        end
        if (!rst_n) begin
            mKnown = 1'b1;
            mBusy  = 1'b0;
            mShown = '0;
        end else if (mBusy) begin
            if (flush) begin
                mBusy = 1'b0;
            end else if (cycle == mDoneCycle) begin
                mBusy  = 1'b0;
                mShown = mResult;
            end
        end else if (busIf.req.is_multicyc && !flush) begin
            mBusy      = 1'b1;
            mDoneCycle = cycle + refLatency(busIf.req.op);
            mResult    = refResult(busIf.req.op, busIf.req.hilo, busIf.req.reg0, busIf.req.reg1);
        end
    end

    // Drives one op (caller is just after a rising edge with the unit idle),
    // waits for its response and checks it against literals; returns just
    // after the rising edge following the response.
    task automatic applyStimulus(input string name, input op_t op, input logic [63:0] hilo,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] expHilo, input int expLat);
        int acc;
        int lat;
        bit got;
        busIf.req.op          = op;
        busIf.req.hilo        = hilo;
        busIf.req.reg0        = a;
        busIf.req.reg1        = b;
        busIf.req.is_multicyc = 1'b1;
        acc = cycle;
        got = 1'b0;
        lat = 0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (busIf.resp.valid) begin
                got = 1'b1;
                lat = cycle - acc;
                checkOutput({name, "_hilo"}, busIf.resp.hilo, expHilo);
            end
        end
        if (got) begin
            checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
        end else begin
            nChecks++;
            $display("[TB] FAIL %s_timeout: no valid within 60 cycles, expected latency %0d", name, expLat);
        end
        @(posedge clk);
        #1;
        busIf.req.is_multicyc = 1'b0;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       pickOperand = 32'h0000_0000;
            1:       pickOperand = 32'h0000_0001;
            2:       pickOperand = 32'hFFFF_FFFF;
            3:       pickOperand = 32'h8000_0000;
            4:       pickOperand = 32'h7FFF_FFFF;
            5:       pickOperand = 32'($urandom_range(0, 255));
            default: pickOperand = $urandom;
        endcase
    endfunction

    task automatic randomPhase(input int nOps);
        int  gap;
        bit  done;
        for (int k = 0; k < nOps; k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                busIf.req.is_multicyc = 1'b0;
                busIf.req.op          = op_t'($urandom_range(0, 11));
                busIf.req.reg0        = $urandom;
                flush                 = 1'b0;
                @(posedge clk);
                #1;
            end
            busIf.req.op          = op_t'($urandom_range(0, 11));
            busIf.req.hilo        = {$urandom, $urandom};
            busIf.req.reg0        = pickOperand();
            busIf.req.reg1        = pickOperand();
            busIf.req.is_multicyc = 1'b1;
            done = 1'b0;
            for (int t = 0; t < 60 && !done; t++) begin
                if (t > 0) begin
                    @(posedge clk);
                    #1;
                end
                flush = ($urandom_range(0, 59) == 0);
                @(negedge clk);
                if (flush || busIf.resp.valid) done = 1'b1;
            end
            if (!done) begin
                nChecks++;
                $display("[TB] FAIL random_timeout: op %0d got no valid within 60 cycles", busIf.req.op);
            end
            @(posedge clk);
            #1;
            flush = 1'b0;
        end
        busIf.req.is_multicyc = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accCycle;
        int seen;
        rst_n     = 1'b0;
        flush     = 1'b0;
        busIf.req = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_valid", 64'(busIf.resp.valid), 64'd0);
        checkOutput("reset_hilo", busIf.resp.hilo, 64'd0);
        @(posedge clk);
        #1;

        applyStimulus("mult_neg", OP_MULT, 64'd0, 32'hFFFF_FFFD, 32'h0000_0005,
                      64'hFFFF_FFFF_FFFF_FFF1, 2);
        applyStimulus("multu_max", OP_MULTU, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      64'hFFFF_FFFE_0000_0001, 2);
        applyStimulus("madd", OP_MADD, 64'h0000_0000_0000_0010, 32'd4, 32'd4,
                      64'h0000_0000_0000_0020, 2);
        applyStimulus("msubu_wrap", OP_MSUBU, 64'd0, 32'd1, 32'd1,
                      64'hFFFF_FFFF_FFFF_FFFF, 2);
        applyStimulus("div_neg", OP_DIV, 64'd0, 32'hFFFF_FFF9, 32'h0000_0002,
                      64'hFFFF_FFFF_FFFF_FFFD, 34);
        applyStimulus("divu_zero", OP_DIVU, 64'd0, 32'h1234_5678, 32'd0,
                      64'h1234_5678_FFFF_FFFF, 34);
        applyStimulus("div_ovf", OP_DIV, 64'd0, 32'h8000_0000, 32'hFFFF_FFFF,
                      64'h0000_0000_8000_0000, 34);
        applyStimulus("div_zero_s", OP_DIV, 64'd0, 32'hFFFF_FFF0, 32'd0,
                      64'hFFFF_FFF0_FFFF_FFFF, 34);
        applyStimulus("other_op", OP_MTHI, 64'hDEAD_BEEF_0BAD_F00D, 32'd7, 32'd9,
                      64'hDEAD_BEEF_0BAD_F00D, 1);

        // Flush a divide ten cycles in, then start a multiply right after.
        busIf.req.op          = OP_DIVU;
        busIf.req.hilo        = 64'd0;
        busIf.req.reg0        = 32'd100;
        busIf.req.reg1        = 32'd7;
        busIf.req.is_multicyc = 1'b1;
        accCycle = cycle;
        seen = 0;
        while (cycle < accCycle + 10) begin
            @(negedge clk);
            if (busIf.resp.valid) seen++;
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        if (busIf.resp.valid) seen++;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_no_valid", 64'(seen), 64'd0);
        applyStimulus("mult_after_flush", OP_MULT, 64'd0, 32'd2, 32'd3, 64'd6, 2);

        // Reset in the middle of a divide.
        busIf.req.op          = OP_DIVU;
        busIf.req.reg0        = 32'd1000;
        busIf.req.reg1        = 32'd3;
        busIf.req.is_multicyc = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        busIf.req.is_multicyc = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_valid", 64'(busIf.resp.valid), 64'd0);
        checkOutput("midrst_hilo", busIf.resp.hilo, 64'd0);
        @(posedge clk);
        #1;
        applyStimulus("after_reset", OP_MULTU, 64'd0, 32'd10, 32'd11, 64'd110, 2);

        // Held request across DONE, then a divide issued the very next cycle.
        applyStimulus("mult_held", OP_MULT, 64'd0, 32'd5, 32'hFFFF_FFFF,
                      64'hFFFF_FFFF_FFFF_FFFB, 2);
        applyStimulus("divu_b2b", OP_DIVU, 64'd0, 32'd9, 32'd3, 64'h0000_0000_0000_0003, 34);

        randomPhase(70);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
